// File: rtl/uart_16550_rx.sv
// 16550-compatible UART receiver: synchroniser, bit-timing FSM, FWFT byte FIFO and sticky LSR flags.
// Optional UART_RX_PARITY_EN adds a parity bit between data and stop plus a sticky parity_err flag.
module uart_16550_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  input  logic [15:0]                   baud_divisor,
  input  logic                          rd_en,
  input  logic                          err_clr,
`ifdef UART_RX_PARITY_EN
  input  logic                          parity_en,
  input  logic                          parity_even,
  output logic                          parity_err,
`endif
  output logic [7:0]                    rx_data,
  output logic                          data_ready,
  output logic                          overrun_err,
  output logic                          framing_err,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push, set_fe;
`ifdef UART_RX_PARITY_EN
  logic        set_pe, pe_q;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          pop, full, wr, ovr;
  logic          oe_q, fe_q;

  // Synchroniser presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_fe    = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_pe    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (!rx_s) begin
          state_d = START;
          cnt_d   = baud_divisor >> 1;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          if (!rx_s) begin
            state_d   = DATA;
            cnt_d     = baud_divisor;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = baud_divisor;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = parity_en ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd0) begin
          // Odd total ones is an error for even parity, even total for odd parity.
          set_pe  = parity_even ? (^shift_q ^ rx_s) : ~(^shift_q ^ rx_s);
          cnt_d   = baud_divisor;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd0) begin
          push = 1'b1;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            set_fe  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees the slot a same-cycle push needs, so full+pop+push is not an overrun.
  assign pop  = rd_en && (count_q != '0);
  assign full = (count_q == FULL_CNT);
  assign wr   = push && (!full || pop);
  assign ovr  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shift_q;
  end

  // Sticky flags: a set on the same edge as err_clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      oe_q <= (oe_q & ~err_clr) | ovr;
      fe_q <= (fe_q & ~err_clr) | set_fe;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) pe_q <= 1'b0;
    else        pe_q <= (pe_q & ~err_clr) | set_pe;
  end
  assign parity_err = pe_q;
`endif

  assign rx_data     = (count_q != '0) ? mem[rd_ptr] : 8'h00;
  assign data_ready  = (count_q != '0);
  assign overrun_err = oe_q;
  assign framing_err = fe_q;
  assign rx_busy     = (state_q != IDLE);
  assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_16550_rx.sv
// Directed bench for uart_16550_rx: serial frames in, a queue model of FIFO contents and flags checked every idle cycle.
module tb_uart_16550_rx;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [15:0] baud_divisor = 16'd15;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  rx_data;
  logic        data_ready, overrun_err, framing_err, rx_busy;
  logic [4:0]  fifo_count;

  uart_16550_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .baud_divisor(baud_divisor),
    .rd_en(rd_en), .err_clr(err_clr), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_err(overrun_err), .framing_err(framing_err), .rx_busy(rx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  byte unsigned mq[$];
  bit exp_oe = 1'b0;
  bit exp_fe = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: receiver stores whole bytes in arrival order, drops them when 16 are held.
  task automatic model_push(input byte unsigned b);
    if (mq.size() == DEPTH) exp_oe = 1'b1;
    else mq.push_back(b);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_ready", data_ready, mq.size() != 0);
      chk("rx_data", rx_data, (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("fifo_count", fifo_count, mq.size());
      chk("overrun_err", overrun_err, exp_oe);
      chk("framing_err", framing_err, exp_fe);
      chk("rx_busy", rx_busy, 0);
    end
  end

  // One 8N1 frame at the current divisor; stop_lo>0 holds the line low for that many periods from the stop bit.
  task automatic send(input logic [7:0] b, input int stop_lo, input bit rd_at_push,
                      input bit clr_at_push, output int seen_k);
    int p, lat, total;
    bit dr0;
    p     = int'(baud_divisor) + 1;
    lat   = SYNC + 1 + int'(baud_divisor >> 1) + 1 + 9 * p;
    total = (stop_lo > 0 ? 9 + stop_lo : 10) * p + 6;
    chk_en = 1'b0;
    seen_k = -1;
    dr0    = data_ready;
    for (int k = 0; k < total; k++) begin
      int idx;
      @(posedge clk);
      #1;
      if (seen_k < 0 && data_ready && !dr0) seen_k = k;
      idx = k / p;
      if (idx == 0)                               uart_rx = 1'b0;
      else if (idx <= 8)                          uart_rx = b[idx-1];
      else if (stop_lo > 0 && idx < 9 + stop_lo)  uart_rx = 1'b0;
      else                                        uart_rx = 1'b1;
      rd_en   = rd_at_push  && (k == lat - 1);
      err_clr = clr_at_push && (k == lat - 1);
    end
    rd_en = 1'b0; err_clr = 1'b0; uart_rx = 1'b1;
    if (clr_at_push) begin exp_oe = 1'b0; exp_fe = 1'b0; end
    if (rd_at_push && mq.size() != 0) void'(mq.pop_front());
    model_push(b);
    if (stop_lo > 0) exp_fe = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] exp_b);
    @(posedge clk); #1 rd_en = 1'b1;
    chk("read_head", rx_data, exp_b);
    @(posedge clk); #1 rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_clear();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    exp_oe = 1'b0; exp_fe = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_dr"}, data_ready, 1'b0);
    chk({tag, "_oe"}, overrun_err, 1'b0);
    chk({tag, "_fe"}, framing_err, 1'b0);
    chk({tag, "_busy"}, rx_busy, 1'b0);
    chk({tag, "_count"}, fifo_count, 5'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_state("reset");
    chk_en = 1'b1;

    // Basic frame, latency bound 9.5*16 + SYNC + 2 from the falling edge
    send(8'hA5, 0, 0, 0, seen);
    chk("a5_latency_seen", seen >= 0, 1'b1);
    chk("a5_latency_bound", seen <= 9 * 16 + 8 + SYNC + 2, 1'b1);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_count", fifo_count, 5'd1);
    do_read(8'hA5);
    #1;
    chk("a5_after_read_dr", data_ready, 1'b0);
    chk("a5_after_read_data", rx_data, 8'h00);

    // Short bit period
    baud_divisor = 16'd4;
    send(8'hC3, 0, 0, 0, seen);
    chk("c3_rx_data", rx_data, 8'hC3);
    do_read(8'hC3);
    baud_divisor = 16'd15;

    // 4-clock glitch is rejected at the mid-bit check
    chk_en = 1'b0;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy_mid", rx_busy, 1'b1);
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_busy_end", rx_busy, 1'b0);
    chk("glitch_count", fifo_count, 5'd0);
    chk("glitch_fe", framing_err, 1'b0);
    chk_en = 1'b1;

    // Framing error followed by a break; byte kept, no second byte
    send(8'h3C, 3, 0, 0, seen);
    repeat (40) @(posedge clk);
    #1;
    chk("brk_fe", framing_err, 1'b1);
    chk("brk_count", fifo_count, 5'd1);
    chk("brk_data", rx_data, 8'h3C);
    do_clear();
    #1;
    chk("brk_fe_cleared", framing_err, 1'b0);
    do_read(8'h3C);

    // Overrun: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send(8'(i), 0, 0, 0, seen);
    chk("ovr_count", fifo_count, 5'd16);
    chk("ovr_flag", overrun_err, 1'b1);
    for (int i = 0; i < 16; i++) do_read(8'(i));
    #1;
    chk("ovr_drained_dr", data_ready, 1'b0);
    do_clear();

    // Pop coinciding with a push while full, then err_clr coinciding with an overrun
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 0, 0, 0, seen);
    send(8'h55, 0, 1, 0, seen);
    chk("popush_count", fifo_count, 5'd16);
    chk("popush_oe", overrun_err, 1'b0);
    chk("popush_head", rx_data, 8'h21);
    send(8'h66, 0, 0, 1, seen);
    chk("clr_vs_set_oe", overrun_err, 1'b1);
    chk("clr_vs_set_count", fifo_count, 5'd16);
    for (int i = 1; i < 16; i++) do_read(8'h20 + 8'(i));
    do_read(8'h55);
    do_clear();

    // Reset during data bit 4 discards FIFO and partial frame
    send(8'h77, 0, 0, 0, seen);
    chk_en = 1'b0;
    for (int k = 0; k < 5 * 16 + 8; k++) begin
      @(posedge clk); #1;
      uart_rx = (k < 16) ? 1'b0 : 1'b0;
    end
    rst_n = 1'b0; uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); exp_oe = 1'b0; exp_fe = 1'b0;
    chk_reset_state("midrst");
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b1;
    send(8'h5A, 0, 0, 0, seen);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_count", fifo_count, 5'd1);
    chk("post_rst_oe", overrun_err, 1'b0);
    chk("post_rst_fe", framing_err, 1'b0);
    do_read(8'h5A);
    repeat (4) @(posedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
